// File: rtl/hdmi_rx_decode_pkg.sv
// Shared types and constants for the TMDS sink-side decoder.
// Holds the control tokens, the per-channel bundle, the lock states and the RGB565 pack helper.
package hdmi_rx_decode_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_LOCK_CNT = 8;
    localparam int DEF_ERR_MAX  = 4;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    typedef struct packed {
        logic       ctl;
        logic [1:0] c;
        logic [7:0] d;
    } ch_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    function automatic logic [15:0] pack565(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/hdmi_rx_decode_ch.sv
// One TMDS channel: 10-bit symbol to {ctl, c, d}, registered once.
// Control tokens yield ctl=1 with the C pair; anything else is decoded as data.
module hdmi_rx_decode_ch
    import hdmi_rx_decode_pkg::*;
(
    input  logic       vga_clk,
    input  logic       reset,
    input  logic [9:0] sym,
    output ch_t        ch
);

    ch_t        dec;
    logic [7:0] v;

    // Combinational token match and transition-minimised data decode.
    always_comb begin
        v       = sym[9] ? ~sym[7:0] : sym[7:0];
        dec     = '0;
        dec.d[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            dec.d[i] = sym[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        end
        case (sym)
            TOK_C00: begin dec = '0; dec.ctl = 1'b1; dec.c = 2'b00; end
            TOK_C01: begin dec = '0; dec.ctl = 1'b1; dec.c = 2'b01; end
            TOK_C10: begin dec = '0; dec.ctl = 1'b1; dec.c = 2'b10; end
            TOK_C11: begin dec = '0; dec.ctl = 1'b1; dec.c = 2'b11; end
            default: ;
        endcase
    end

    // Stage-1 register for this channel.
    always_ff @(posedge vga_clk) begin
        if (reset) ch <= '0;
        else       ch <= dec;
    end

endmodule

// File: rtl/hdmi_rx_decode.sv
// TMDS receive decoder: three channel decoders, classifier, lock FSM and x/y counters.
// Outputs follow VGA controller conventions with a fixed two-cycle symbol latency.
module hdmi_rx_decode
    import hdmi_rx_decode_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int ERR_MAX  = DEF_ERR_MAX
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic [9:0]  tmds_b,
    input  logic [9:0]  tmds_g,
    input  logic [9:0]  tmds_r,
    output logic [15:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        locked,
    output logic        sym_err,
    output logic        geom_err
);

    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_MAX + 1);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);

    ch_t ch_b, ch_g, ch_r;

    hdmi_rx_decode_ch u_ch_b (.vga_clk(vga_clk), .reset(reset), .sym(tmds_b), .ch(ch_b));
    hdmi_rx_decode_ch u_ch_g (.vga_clk(vga_clk), .reset(reset), .sym(tmds_g), .ch(ch_g));
    hdmi_rx_decode_ch u_ch_r (.vga_clk(vga_clk), .reset(reset), .sym(tmds_r), .ch(ch_r));

    logic unused_c;
    assign unused_c = ^{ch_g.c, ch_r.c};

    logic valid_ctl, valid_data;
    assign valid_ctl  = ch_b.ctl & ch_g.ctl & ch_r.ctl;
    assign valid_data = ~(ch_b.ctl | ch_g.ctl | ch_r.ctl);

    lock_state_t   state, state_n;
    logic [LW-1:0] lock_cnt, lock_cnt_n;
    logic [EW-1:0] err_cnt, err_cnt_n;

    logic [15:0] rgb_n;
    logic        hsync_n, vsync_n, de_n, sym_err_n, geom_err_n;
    logic [9:0]  pix_x_n, pix_y_n;
    logic        y_ovf, y_ovf_n;
    logic        vs_edge, de_fall;

    assign locked = (state == LOCKED);

    // Lock state and its run-length counters.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state    <= UNLOCKED;
            lock_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_cnt_n;
            err_cnt  <= err_cnt_n;
        end
    end

    // Next lock state: count control runs to lock, invalid runs to drop.
    always_comb begin
        state_n    = state;
        lock_cnt_n = '0;
        err_cnt_n  = '0;
        unique case (state)
            UNLOCKED: begin
                if (valid_ctl) begin
                    if (lock_cnt == LW'(LOCK_CNT - 1)) state_n = LOCKED;
                    else lock_cnt_n = lock_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (!valid_ctl && !valid_data) begin
                    if (err_cnt == EW'(ERR_MAX - 1)) state_n = UNLOCKED;
                    else err_cnt_n = err_cnt + 1'b1;
                end
            end
            default: state_n = UNLOCKED;
        endcase
    end

    // Next output values: syncs, pixel data and x/y geometry tracking.
    always_comb begin
        rgb_n      = '0;
        de_n       = 1'b0;
        hsync_n    = hsync;
        vsync_n    = vsync;
        pix_x_n    = '0;
        pix_y_n    = pix_y;
        sym_err_n  = 1'b0;
        geom_err_n = 1'b0;
        y_ovf_n    = y_ovf;
        vs_edge    = 1'b0;
        de_fall    = 1'b0;
        unique case (state)
            UNLOCKED: begin
                if (ch_b.ctl) begin
                    hsync_n = ch_b.c[0];
                    vsync_n = ch_b.c[1];
                end
                pix_y_n = '0;
                y_ovf_n = 1'b0;
            end
            LOCKED: begin
                if (valid_ctl) begin
                    hsync_n = ch_b.c[0];
                    vsync_n = ch_b.c[1];
                    vs_edge = (ch_b.c[1] != vsync);
                end else if (valid_data) begin
                    de_n  = 1'b1;
                    rgb_n = pack565(ch_r.d, ch_g.d, ch_b.d);
                    if (!de) begin
                        pix_x_n = '0;
                    end else if (pix_x == X_MAX) begin
                        pix_x_n    = X_MAX;
                        geom_err_n = 1'b1;
                    end else begin
                        pix_x_n = pix_x + 10'd1;
                    end
                end else begin
                    sym_err_n = 1'b1;
                end
                de_fall = de & ~de_n;
                if (vs_edge) begin
                    pix_y_n = '0;
                    y_ovf_n = 1'b0;
                end else if (de_fall) begin
                    if (pix_y == Y_MAX) begin
                        if (y_ovf) geom_err_n = 1'b1;
                        else       y_ovf_n    = 1'b1;
                    end else begin
                        pix_y_n = pix_y + 10'd1;
                    end
                end
                if (state_n == UNLOCKED) begin
                    pix_x_n = '0;
                    pix_y_n = '0;
                    y_ovf_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Stage-2 output registers.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            rgb      <= '0;
            hsync    <= 1'b0;
            vsync    <= 1'b0;
            de       <= 1'b0;
            pix_x    <= '0;
            pix_y    <= '0;
            sym_err  <= 1'b0;
            geom_err <= 1'b0;
            y_ovf    <= 1'b0;
        end else begin
            rgb      <= rgb_n;
            hsync    <= hsync_n;
            vsync    <= vsync_n;
            de       <= de_n;
            pix_x    <= pix_x_n;
            pix_y    <= pix_y_n;
            sym_err  <= sym_err_n;
            geom_err <= geom_err_n;
            y_ovf    <= y_ovf_n;
        end
    end

endmodule
